// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Provides FSM state encoding, parity mode codes and default tick count.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int DEF_OS_TICK = 16;

    // Mode 2'b11 is reserved and behaves as no parity.
    function automatic logic par_enabled(input logic [1:0] mode);
        logic en;
        en = 1'b0;
        unique case (mode)
            PAR_NONE: en = 1'b0;
            PAR_EVEN: en = 1'b1;
            PAR_ODD:  en = 1'b1;
            default:  en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO feeding the UART serialiser.
// Ports: clk, rst (async high), push/din, pop/dout, full, empty, count.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int FIFO_AW = 2,
    parameter int DEPTH   = 1 << FIFO_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [DBITS-1:0]   din,
    output logic [DBITS-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);

    localparam int CW = FIFO_AW + 1;

    logic [DBITS-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               push_ok;
    logic               pop_ok;

    // Writes against a full FIFO are dropped, never deferred.
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter paced by a 16x sample_tick strobe.
// Ports: wr_en/wr_data in, full/empty/fifo_count/overflow status,
// tx serial out, tx_busy/tx_done/state_out for debug.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DBITS      = 8,
    parameter int SB_TICK    = 16,
    parameter int OS_TICK    = DEF_OS_TICK,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic [1:0]       parity_mode,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] fifo_count,
    output logic             overflow,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [2:0]       state_out
);

    localparam int MAXT = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
    localparam int TW   = $clog2(MAXT);
    localparam int BW   = $clog2(DBITS);

    state_e           state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DBITS-1:0] shreg_q, shreg_d;
    logic             par_bit_q, par_bit_d;
    logic             par_en_q, par_en_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q;

    logic             fifo_pop;
    logic [DBITS-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             os_last;
    logic             sb_last;

    uart_tx_fifo #(
        .DBITS   (DBITS),
        .FIFO_AW (FIFO_AW),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_100MHz),
        .rst   (reset),
        .push  (wr_en),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign os_last = (tick_q == TW'(OS_TICK - 1));
    assign sb_last = (tick_q == TW'(SB_TICK - 1));

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        done_d    = 1'b0;
        fifo_pop  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Start immediately; sample_tick is not awaited here.
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shreg_d   = fifo_dout;
                    par_en_d  = par_enabled(parity_mode);
                    par_bit_d = (^fifo_dout) ^ (parity_mode == PAR_ODD);
                    tick_d    = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (sample_tick) begin
                    if (os_last) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (sample_tick) begin
                    if (os_last) begin
                        tick_d  = '0;
                        shreg_d = shreg_q >> 1;
                        if (bit_q == BW'(DBITS - 1)) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (sample_tick) begin
                    if (os_last) begin
                        tick_d  = '0;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (sample_tick) begin
                    if (sb_last) begin
                        tick_d  = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level is registered from the next state to keep tx glitch-free.
        unique case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_bit_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= wr_en && fifo_full;
        end
    end

    assign full      = fifo_full;
    assign empty     = fifo_empty;
    assign overflow  = ovf_q;
    assign tx        = tx_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;
    assign state_out = state_q;

endmodule
